// File: rtl/jump_ctrl_pkg.sv
// rtl/jump_ctrl_pkg.sv - shared encodings, state type and output decode for the jump sequencer
package jump_ctrl_pkg;

    localparam logic [1:0] PC_SRC_SEQ  = 2'd0;
    localparam logic [1:0] PC_SRC_ALU  = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;
    localparam logic [1:0] PC_SRC_REG  = 2'd3;

    localparam logic [4:0] RA_INDEX = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DECODE   = 3'd1,
        J_EXEC   = 3'd2,
        JAL_LINK = 3'd3,
        JAL_JUMP = 3'd4,
        JR_EXEC  = 3'd5,
        DONE     = 3'd6,
        ERR      = 3'd7
    } state_t;

    typedef struct packed {
        logic       busy;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       reg_write;
        logic [4:0] reg_wr_addr;
        logic       link_sel;
        logic       done;
        logic       illegal;
    } seq_out_t;

    // Moore output table; the FSM registers this for the state it is entering.
    function automatic seq_out_t state_outputs(input state_t s);
        seq_out_t o;
        o        = '0;
        o.pc_src = PC_SRC_SEQ;
        case (s)
            IDLE: begin
            end
            DECODE: begin
                o.busy = 1'b1;
            end
            J_EXEC: begin
                o.busy     = 1'b1;
                o.pc_src   = PC_SRC_JUMP;
                o.pc_write = 1'b1;
            end
            JAL_LINK: begin
                o.busy        = 1'b1;
                o.reg_write   = 1'b1;
                o.reg_wr_addr = RA_INDEX;
                o.link_sel    = 1'b1;
            end
            JAL_JUMP: begin
                o.busy     = 1'b1;
                o.pc_src   = PC_SRC_JUMP;
                o.pc_write = 1'b1;
            end
            JR_EXEC: begin
                o.busy     = 1'b1;
                o.pc_src   = PC_SRC_REG;
                o.pc_write = 1'b1;
            end
            DONE: begin
                o.busy = 1'b1;
                o.done = 1'b1;
            end
            ERR: begin
                o.busy    = 1'b1;
                o.illegal = 1'b1;
            end
            default: begin
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/jump_decode.sv
// rtl/jump_decode.sv - one-hot classification of a latched opcode/funct as J, JAL, JR or illegal
module jump_decode
    import jump_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic       o_is_j,
    output logic       o_is_jal,
    output logic       o_is_jr,
    output logic       o_is_illegal
);

    logic w_is_j;
    logic w_is_jal;
    logic w_is_jr;

    assign w_is_j   = (i_opcode == OP_J);
    assign w_is_jal = (i_opcode == OP_JAL);
    assign w_is_jr  = (i_opcode == OP_RTYPE) && (i_funct == FN_JR);

    assign o_is_j       = w_is_j;
    assign o_is_jal     = w_is_jal;
    assign o_is_jr      = w_is_jr;
    assign o_is_illegal = !(w_is_j || w_is_jal || w_is_jr);

endmodule

// File: rtl/jump_sequencer.sv
// rtl/jump_sequencer.sv - multicycle sequencer driving PC select/write and $ra link for J, JAL, JR
module jump_sequencer
    import jump_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       busy,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       reg_write,
    output logic [4:0] reg_wr_addr,
    output logic       link_sel,
    output logic       done,
    output logic       illegal
);

    state_t   r_state;
    seq_out_t r_out;
    logic [5:0] r_opcode;
    logic [5:0] r_funct;

    state_t w_next_state;
    logic   w_is_j;
    logic   w_is_jal;
    logic   w_is_jr;
    logic   w_is_illegal;

    jump_decode u_decode (
        .i_opcode     (r_opcode),
        .i_funct      (r_funct),
        .o_is_j       (w_is_j),
        .o_is_jal     (w_is_jal),
        .o_is_jr      (w_is_jr),
        .o_is_illegal (w_is_illegal)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                if (w_is_illegal) begin
                    w_next_state = ERR;
                end else if (w_is_j) begin
                    w_next_state = J_EXEC;
                end else if (w_is_jal) begin
                    w_next_state = JAL_LINK;
                end else if (w_is_jr) begin
                    w_next_state = JR_EXEC;
                end else begin
                    w_next_state = ERR;
                end
            end
            J_EXEC:   w_next_state = DONE;
            JAL_LINK: w_next_state = JAL_JUMP;
            JAL_JUMP: w_next_state = DONE;
            JR_EXEC:  w_next_state = DONE;
            DONE:     w_next_state = IDLE;
            ERR:      w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_out    <= state_outputs(IDLE);
            r_opcode <= '0;
            r_funct  <= '0;
        end else begin
            r_state <= w_next_state;
            r_out   <= state_outputs(w_next_state);
            if ((r_state == IDLE) && start) begin
                r_opcode <= opcode;
                r_funct  <= funct;
            end
        end
    end

    assign busy        = r_out.busy;
    assign pc_src      = r_out.pc_src;
    assign pc_write    = r_out.pc_write;
    assign reg_write   = r_out.reg_write;
    assign reg_wr_addr = r_out.reg_wr_addr;
    assign link_sel    = r_out.link_sel;
    assign done        = r_out.done;
    assign illegal     = r_out.illegal;

endmodule

// File: tb/tb_jump_sequencer.sv
// tb/tb_jump_sequencer.sv - scoreboard bench for jump_sequencer with randomized instruction stream
module tb_jump_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       busy;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       reg_write;
    logic [4:0] reg_wr_addr;
    logic       link_sel;
    logic       done;
    logic       illegal;

    jump_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opcode      (opcode),
        .funct       (funct),
        .busy        (busy),
        .pc_src      (pc_src),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .reg_wr_addr (reg_wr_addr),
        .link_sel    (link_sel),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind bits: {pc_write, reg_write, done, illegal}
    typedef struct {
        int         cyc;
        logic [3:0] kind;
        logic [1:0] src;
        logic [4:0] addr;
        logic       link;
    } ev_t;

    ev_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int busy_from = -1;
    int busy_until = 0;
    int free_cyc = 0;
    int n_accept = 0;
    int n_killed = 0;
    int exp_pcw = 0, exp_regw = 0, exp_done = 0, exp_ill = 0;
    int obs_pcw = 0, obs_regw = 0, obs_done = 0, obs_ill = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic [3:0] k, input logic [1:0] s,
                           input logic [4:0] a, input logic l);
        ev_t e;
        e.cyc = c; e.kind = k; e.src = s; e.addr = a; e.link = l;
        sb.push_back(e);
        if (k == 4'b1000) exp_pcw++;
        if (k == 4'b0100) exp_regw++;
        if (k == 4'b0010) exp_done++;
        if (k == 4'b0001) exp_ill++;
    endtask

    // Reference behaviour: what each accepted instruction must produce, and when.
    task automatic accept(input logic [5:0] op, input logic [5:0] fn, input int c);
        n_accept++;
        busy_from = c;
        if (op == 6'h02) begin
            push_ev(c + 2, 4'b1000, 2'd2, 5'd0, 1'b0);
            push_ev(c + 3, 4'b0010, 2'd0, 5'd0, 1'b0);
            free_cyc = c + 4;
        end else if (op == 6'h03) begin
            push_ev(c + 2, 4'b0100, 2'd0, 5'd31, 1'b1);
            push_ev(c + 3, 4'b1000, 2'd2, 5'd0, 1'b0);
            push_ev(c + 4, 4'b0010, 2'd0, 5'd0, 1'b0);
            free_cyc = c + 5;
        end else if (op == 6'h00 && fn == 6'h08) begin
            push_ev(c + 2, 4'b1000, 2'd3, 5'd0, 1'b0);
            push_ev(c + 3, 4'b0010, 2'd0, 5'd0, 1'b0);
            free_cyc = c + 4;
        end else begin
            push_ev(c + 2, 4'b0001, 2'd0, 5'd0, 1'b0);
            free_cyc = c + 3;
        end
        busy_until = free_cyc;
    endtask

    task automatic flush_after(input int r);
        ev_t keep[$];
        foreach (sb[i]) begin
            if (sb[i].cyc <= r) begin
                keep.push_back(sb[i]);
            end else begin
                if (sb[i].kind == 4'b1000) exp_pcw--;
                if (sb[i].kind == 4'b0100) exp_regw--;
                if (sb[i].kind == 4'b0010) begin exp_done--; n_killed++; end
                if (sb[i].kind == 4'b0001) begin exp_ill--; n_killed++; end
            end
        end
        sb = keep;
        if (busy_until > r + 1) busy_until = r + 1;
        if (free_cyc > r + 1) free_cyc = r + 1;
    endtask

    task automatic step(input bit s, input logic [5:0] op, input logic [5:0] fn);
        reset  = 1'b0;
        start  = s;
        opcode = op;
        funct  = fn;
        if (s && cyc >= free_cyc) accept(op, fn, cyc);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'($urandom), 6'($urandom));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset = 1'b1;
            start = 1'b0;
            flush_after(cyc);
            @(negedge clk);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a strobe.
    initial begin
        ev_t        e;
        logic [3:0] obs;
        @(negedge clk);
        forever begin
            obs = {pc_write, reg_write, done, illegal};
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("missed_event_cycle", cyc, e.cyc);
            end
            if (obs != 4'b0000) begin
                obs_pcw  += int'(pc_write);
                obs_regw += int'(reg_write);
                obs_done += int'(done);
                obs_ill  += int'(illegal);
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    chk("strobes", obs, e.kind);
                    chk("pc_src", pc_src, e.src);
                    chk("reg_wr_addr", reg_wr_addr, e.addr);
                    chk("link_sel", link_sel, e.link);
                end else begin
                    chk("unexpected_strobe", obs, 4'b0000);
                end
            end else begin
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    chk("missing_strobe", obs, e.kind);
                end
                chk("idle_pc_src", pc_src, 2'd0);
                chk("idle_reg_wr_addr", reg_wr_addr, 5'd0);
                chk("idle_link_sel", link_sel, 1'b0);
            end
            chk("busy", busy, (cyc > busy_from && cyc < busy_until));
            @(negedge clk);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        int base;
        logic [5:0] op;
        logic [5:0] fn;
        @(negedge clk);
        do_reset(1);

        step(1'b1, 6'h02, 6'h15);      idle(5);
        step(1'b1, 6'h03, 6'h00);      idle(5);
        step(1'b1, 6'h00, 6'h08);      idle(4);
        step(1'b1, 6'h00, 6'h20);      idle(3);

        // Starts while busy and in the done cycle are dropped.
        step(1'b1, 6'h03, 6'h00);
        step(1'b1, 6'h02, 6'h00);
        step(1'b0, 6'h02, 6'h00);
        step(1'b1, 6'h02, 6'h00);
        step(1'b1, 6'h02, 6'h00);
        step(1'b1, 6'h02, 6'h00);
        idle(5);

        // Reset in the link cycle aborts the jump.
        step(1'b1, 6'h03, 6'h00);
        step(1'b0, 6'h00, 6'h00);
        do_reset(1);
        idle(4);

        base = n_accept;
        while (n_accept - base < 50) begin
            fn = 6'($urandom);
            case ($urandom % 6)
                0: op = 6'h02;
                1: op = 6'h03;
                2: begin op = 6'h00; fn = 6'h08; end
                3: op = 6'h00;
                4: op = 6'($urandom);
                default: op = 6'h03;
            endcase
            step(($urandom % 4) != 0, op, fn);
        end
        idle(8);

        chk("pc_write_count", obs_pcw, exp_pcw);
        chk("reg_write_count", obs_regw, exp_regw);
        chk("done_count", obs_done, exp_done);
        chk("illegal_count", obs_ill, exp_ill);
        chk("one_outcome_per_instr", obs_done + obs_ill, n_accept - n_killed);
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
